axis_video_fifo: RTL and testbench
==================================

Name: axis_video_fifo

Overview:
- Elastic AXI4-Stream video buffer between axi_stream_wrapper (master) and the HDMI block design video_in port (slave).
- The upstream timing chain is free-running and cannot stall, so this block absorbs downstream tready backpressure.
- On overflow it discards the rest of the corrupted frame and resynchronises on the next start-of-frame (tuser) beat, so the output never carries a partial frame followed by a new frame without a break.

Parameters:
- DATA_W, 24, pixel data width (RGB888).
- DEPTH, 1024, FIFO entries; power of two, minimum 4.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- pixel_clk  input  1  single clock; all logic is in this domain.
- aresetn  input  1  asynchronous active-low reset.
- s_tdata  input  DATA_W  upstream pixel data.
- s_tvalid  input  1  upstream beat valid.
- s_tuser  input  1  start of frame (first pixel of a frame).
- s_tlast  input  1  end of line.
- s_tready  output  1  accept indication to upstream.
- m_tdata  output  DATA_W  downstream pixel data.
- m_tvalid  output  1  downstream beat valid.
- m_tuser  output  1  start of frame.
- m_tlast  output  1  end of line.
- m_tready  input  1  downstream accept.
- level  output  $clog2(DEPTH)+1  current occupancy.
- overflow_cnt  output  CNT_W  number of beats lost to overflow (saturating).
- drop_frames  output  CNT_W  number of frames entered in the DROP state (saturating).
- in_sync  output  1  high while in the PASS state.

Behaviour:
- Reset: all outputs return to 0.
  - level, overflow_cnt, drop_frames and in_sync are all 0.
  - Pointers are cleared and the state is SYNC.
  - s_tready is 0 while aresetn is low.
  - Asserting aresetn mid-frame empties the FIFO immediately; m_tvalid drops asynchronously.
- Storage: each entry is {tuser, tlast, tdata}, DATA_W+2 bits. Read and write pointers are $clog2(DEPTH)+1 bits wide, with the MSB used for wrap detection.
  - full = (addresses equal, MSBs differ).
  - empty = (pointers equal).
- Write handshake: s_tready = ~full whenever aresetn is high, independent of m_tready in the same cycle. No same-cycle write-on-full, even if a read occurs.
- Read side is first-word fall-through:
  - m_tvalid = ~empty.
  - m_tdata, m_tuser and m_tlast present the head entry.
  - A pop occurs when m_tvalid & m_tready.
  - Latency: a beat written in cycle N is visible on m_* in cycle N+1.
  - m_* must hold stable while m_tvalid=1 and m_tready=0.
- level changes per cycle as follows:
  - +1 on write only.
  - -1 on pop only.
  - Unchanged on simultaneous write and pop, or when neither occurs.
- State machine (2-bit state):
  - SYNC: beats with s_tuser=0 are discarded (not written). A beat with s_tvalid & s_tuser & ~full is written and the state moves to PASS.
  - PASS:
    - s_tvalid & ~full: the beat is written.
    - s_tvalid & full: the beat is lost; overflow_cnt increments; drop_frames increments; the state moves to DROP.
  - DROP:
    - All beats without tuser are discarded; overflow_cnt does not count them.
    - A beat with s_tvalid & s_tuser & ~full is written and the state moves to PASS.
    - A beat with s_tvalid & s_tuser & full is discarded and the state remains DROP; overflow_cnt increments.
- in_sync = (state == PASS), registered.
- While SYNC or DROP discard beats, s_tready still follows ~full. Discarding is internal; the upstream sees no handshake change.
- Already-buffered beats of a dropped frame still drain normally. Downstream sees a truncated frame, then the next tuser.
- Counters saturate at all-ones and never wrap.
- Pointer wrap: an address wraps from DEPTH-1 to 0 and the MSB toggles. Verify continuous streaming across more than 2×DEPTH beats.

Optional Feature:
- AXIS_VIDEO_FIFO_STATS_EN defined: level, overflow_cnt and drop_frames are live as described above.
- Not defined: these three outputs are tied to 0 and their counter registers are not built. FIFO behaviour, the state machine and in_sync are unchanged.

Test Plan:
- Reset, then 3 beats without tuser followed by beat tuser=1 with tdata=0xABCDEF, m_tready=1 → first three beats never appear. 0xABCDEF appears with m_tuser=1 one cycle after acceptance; in_sync=1.
- Sync, then stream 640 beats (tlast every 640th), m_tready=1 → output is identical in order; level ≤ 1; overflow_cnt=0.
- DEPTH=16, sync, m_tready=0, 20 beats → first 16 stored; level=16; s_tready=0; overflow_cnt=1 (the extra beats are in DROP and not counted); drop_frames=1; in_sync=0. Release m_tready → 16 beats drain. Beats without tuser are ignored until a tuser beat arrives, then in_sync=1.
- DEPTH=16, full, simultaneous s_tvalid=1 and pop → write rejected (s_tready=0); level goes to 15 the next cycle.
- Hold m_tready=0 for 5 cycles with m_tvalid=1 → m_tdata/m_tuser/m_tlast stable throughout.
- Assert aresetn low mid-frame with level=7 → level=0, m_tvalid=0, state SYNC. Counters cleared; with AXIS_VIDEO_FIFO_STATS_EN undefined, counters read 0 throughout.

Source files
------------

// File: rtl/axis_video_fifo.sv
// Elastic AXI4-Stream video FIFO with frame resync after overflow.
// Optional statistics outputs built when AXIS_VIDEO_FIFO_STATS_EN is defined.
module axis_video_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 1024,
  parameter int CNT_W  = 16
) (
  input  logic                     pixel_clk,
  input  logic                     aresetn,
  input  logic [DATA_W-1:0]        s_tdata,
  input  logic                     s_tvalid,
  input  logic                     s_tuser,
  input  logic                     s_tlast,
  output logic                     s_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tvalid,
  output logic                     m_tuser,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         overflow_cnt,
  output logic [CNT_W-1:0]         drop_frames,
  output logic                     in_sync
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_W + 2;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [EW-1:0] head;

  logic full;
  logic empty;
  logic wr_en;
  logic pop;

  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                 (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);

  // No write-on-full even with a pop in the same cycle.
  assign s_tready = aresetn & ~full;
  assign pop      = ~empty & m_tready;

  assign head     = mem[rd_ptr[AW-1:0]];
  assign m_tvalid = ~empty;
  assign m_tdata  = empty ? '0 : head[DATA_W-1:0];
  assign m_tlast  = empty ? 1'b0 : head[DATA_W];
  assign m_tuser  = empty ? 1'b0 : head[DATA_W+1];

  assign in_sync = (state == PASS);

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    unique case (state)
      SYNC: begin
        if (s_tvalid && s_tuser && !full) begin
          wr_en     = 1'b1;
          state_nxt = PASS;
        end
      end
      PASS: begin
        if (s_tvalid) begin
          if (!full) begin
            wr_en = 1'b1;
          end else begin
            state_nxt = DROP;
          end
        end
      end
      DROP: begin
        if (s_tvalid && s_tuser && !full) begin
          wr_en     = 1'b1;
          state_nxt = PASS;
        end
      end
      default: begin
        state_nxt = SYNC;
      end
    endcase
  end

  always_ff @(posedge pixel_clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= SYNC;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge pixel_clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage array carries no reset; only pointers define contents.
  always_ff @(posedge pixel_clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {s_tuser, s_tlast, s_tdata};
    end
  end

`ifdef AXIS_VIDEO_FIFO_STATS_EN
  logic             ovf_hit;
  logic             drop_hit;
  logic [CNT_W-1:0] ovf_q;
  logic [CNT_W-1:0] drop_q;

  // A full PASS beat opens a drop; a full tuser beat in DROP is also lost.
  assign drop_hit = s_tvalid & full & (state == PASS);
  assign ovf_hit  = drop_hit |
                    (s_tvalid & full & s_tuser & (state == DROP));

  always_ff @(posedge pixel_clk or negedge aresetn) begin
    if (!aresetn) begin
      ovf_q  <= '0;
      drop_q <= '0;
    end else begin
      if (ovf_hit && (ovf_q != '1)) begin
        ovf_q <= ovf_q + CNT_W'(1);
      end
      if (drop_hit && (drop_q != '1)) begin
        drop_q <= drop_q + CNT_W'(1);
      end
    end
  end

  assign level        = wr_ptr - rd_ptr;
  assign overflow_cnt = ovf_q;
  assign drop_frames  = drop_q;
`else
  assign level        = '0;
  assign overflow_cnt = '0;
  assign drop_frames  = '0;
`endif

endmodule

// File: tb/tb_axis_video_fifo.sv
// Directed bench for axis_video_fifo with an output scoreboard queue.
// Counter expectations follow AXIS_VIDEO_FIFO_STATS_EN.
module tb_axis_video_fifo;

  localparam int DATA_W = 24;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;
  localparam int PW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              aresetn;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tuser;
  logic              s_tlast;
  logic              s_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tuser;
  logic              m_tlast;
  logic              m_tready;
  logic [PW-1:0]     level;
  logic [CNT_W-1:0]  overflow_cnt;
  logic [CNT_W-1:0]  drop_frames;
  logic              in_sync;

  logic [DATA_W+1:0] sb [$];
  int n_chk  = 0;
  int n_fail = 0;

  axis_video_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .pixel_clk   (clk),
    .aresetn     (aresetn),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tuser     (s_tuser),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tuser     (m_tuser),
    .m_tlast     (m_tlast),
    .m_tready    (m_tready),
    .level       (level),
    .overflow_cnt(overflow_cnt),
    .drop_frames (drop_frames),
    .in_sync     (in_sync)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] st(input logic [31:0] v);
`ifdef AXIS_VIDEO_FIFO_STATS_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pix(input int i);
    return DATA_W'(32'h5A0000 ^ (i * 3));
  endfunction

  // Pops happen on the next rising edge; compare at the falling edge.
  always @(negedge clk) begin
    if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
      logic [DATA_W+1:0] exp;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL unexpected_beat got=%0h", {m_tuser, m_tlast, m_tdata});
      end else begin
        exp = sb.pop_front();
        n_chk++;
        assert ({m_tuser, m_tlast, m_tdata} === exp) else begin
          n_fail++;
          $error("FAIL beat got=%0h exp=%0h",
                 {m_tuser, m_tlast, m_tdata}, exp);
        end
      end
    end
  end

  task automatic send(input logic u, input logic l,
                      input logic [DATA_W-1:0] d);
    s_tvalid = 1'b1;
    s_tuser  = u;
    s_tlast  = l;
    s_tdata  = d;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 200 && sb.size() > 0; k++) @(posedge clk);
    #1;
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    int maxl;
    aresetn  = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow_cnt, 0);
    chk("rst_drop", drop_frames, 0);
    chk("rst_sync", in_sync, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_tvalid", m_tvalid, 0);
    aresetn = 1'b1;
    #1;
    chk("tready_up", s_tready, 1);

    // Leading beats without tuser are discarded until start of frame.
    m_tready = 1'b1;
    send(1'b0, 1'b0, 24'h000001);
    send(1'b0, 1'b0, 24'h000002);
    send(1'b0, 1'b0, 24'h000003);
    chk("sync_discard", m_tvalid, 0);
    chk("sync_state", in_sync, 0);
    sb.push_back({1'b1, 1'b0, 24'hABCDEF});
    send(1'b1, 1'b0, 24'hABCDEF);
    chk("first_valid", m_tvalid, 1);
    chk("first_data", m_tdata, 32'hABCDEF);
    chk("first_user", m_tuser, 1);
    chk("first_insync", in_sync, 1);
    drain("t1_drain");

    // Continuous 640-beat line, wraps pointers many times.
    maxl = 0;
    for (int i = 0; i < 640; i++) begin
      sb.push_back({(i == 0), (i == 639), pix(i)});
      send((i == 0), (i == 639), pix(i));
      if (int'(level) > maxl) maxl = int'(level);
    end
    chk("stream_level_le1", (maxl <= 1), 1);
    drain("t2_drain");
    chk("stream_ovf", overflow_cnt, 0);
    chk("stream_empty", m_tvalid, 0);

    // Overflow: 16 stored, 17th lost, rest discarded in DROP.
    m_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i < DEPTH) sb.push_back({(i == 0), 1'b0, pix(1000 + i)});
      send((i == 0), 1'b0, pix(1000 + i));
    end
    chk("full_level", level, st(16));
    chk("full_tready", s_tready, 0);
    chk("full_ovf", overflow_cnt, st(1));
    chk("full_drop", drop_frames, st(1));
    chk("full_insync", in_sync, 0);

    // Write attempt while full and popping is still rejected.
    s_tvalid = 1'b1;
    s_tuser  = 1'b1;
    s_tdata  = 24'h777777;
    m_tready = 1'b1;
    #1;
    chk("full_pop_tready", s_tready, 0);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    m_tready = 1'b0;
    chk("full_pop_level", level, st(15));
    chk("full_tuser_ovf", overflow_cnt, st(2));
    chk("full_pop_insync", in_sync, 0);

    // Head must hold while stalled.
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", m_tvalid, 1);
      chk("hold_data", m_tdata, pix(1001));
      chk("hold_user", m_tuser, 0);
      chk("hold_last", m_tlast, 0);
    end
    m_tready = 1'b1;
    drain("t3_drain");
    chk("drained_level", level, 0);

    send(1'b0, 1'b0, 24'h111111);
    send(1'b0, 1'b1, 24'h222222);
    chk("drop_ignore", m_tvalid, 0);
    chk("drop_insync", in_sync, 0);
    sb.push_back({1'b1, 1'b0, 24'h333333});
    send(1'b1, 1'b0, 24'h333333);
    chk("resync_insync", in_sync, 1);
    drain("t4_drain");

    // Reset mid-frame with 7 buffered beats.
    m_tready = 1'b0;
    for (int i = 0; i < 7; i++) send(1'b0, 1'b0, pix(2000 + i));
    chk("pre_rst_level", level, st(7));
    chk("pre_rst_valid", m_tvalid, 1);
    aresetn = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_valid", m_tvalid, 0);
    chk("arst_data", m_tdata, 0);
    chk("arst_insync", in_sync, 0);
    chk("arst_ovf", overflow_cnt, 0);
    chk("arst_drop", drop_frames, 0);
    chk("arst_tready", s_tready, 0);
    @(posedge clk);
    #1;
    aresetn  = 1'b1;
    m_tready = 1'b1;
    send(1'b0, 1'b0, 24'h444444);
    chk("post_rst_sync", m_tvalid, 0);
    chk("post_rst_insync", in_sync, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
